// File: rtl/hw_accel_ram_reader_pkg.sv
// ============================================================================
// Package : hw_accel_ram_reader_pkg
// Brief   : Shared FSM encoding and FIFO/credit sizing for the RAM stream reader.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package hw_accel_ram_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PTR_W = 2;
    // Wide enough to hold 0..FIFO_DEPTH inclusive
    localparam int CREDIT_W   = 3;

endpackage

`default_nettype wire

// File: rtl/hw_accel_ram_reader_fifo.sv
// ============================================================================
// Module  : hw_accel_ram_reader_fifo
// Brief   : 4-entry flop FIFO with a registered head; rd_data is the head word.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module hw_accel_ram_reader_fifo
    import hw_accel_ram_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  valid,
    output logic [CREDIT_W-1:0]   count
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CREDIT_W-1:0]   count_q, count_d;
    logic                  do_rd;

    assign valid   = (count_q != '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_rd   = rd_en & valid;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + FIFO_PTR_W'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + FIFO_PTR_W'(1);
        end
        count_d = count_q + CREDIT_W'(wr_en) - CREDIT_W'(do_rd);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hw_accel_ram_stream_reader.sv
// ============================================================================
// Module  : hw_accel_ram_stream_reader
// Brief   : Burst reader: issues sequential RAM reads and streams the words out
//           under credit flow control. Macro HW_ACCEL_RAM_READER_LAST_EN adds m_last.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module hw_accel_ram_stream_reader
    import hw_accel_ram_reader_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_rd,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef HW_ACCEL_RAM_READER_LAST_EN
    ,
    output logic                  m_last
`endif
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH+1)'(1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    rd_q, rd_d;
    logic [ADDR_WIDTH:0]     iss_left_q, iss_left_d;
    logic [ADDR_WIDTH:0]     beats_left_q, beats_left_d;
    logic [CREDIT_W-1:0]     inflight_q, inflight_d;
    logic                    zero_done_q, zero_done_d;
    logic [READ_LATENCY-1:0] cap_sr_q, cap_sr_d;

    logic                    cap;
    logic                    pop;
    logic                    last_accept;
    logic                    credit_ok;
    logic [CREDIT_W:0]       used;
    logic [CREDIT_W-1:0]     fifo_count;
    logic                    fifo_valid;
    logic [DATA_WIDTH-1:0]   fifo_data;

    // Delay line marking the cycle in which each issued read's data is on ram_rdata
    if (READ_LATENCY == 1) begin : g_lat1
        assign cap_sr_d = rd_q;
    end else begin : g_latn
        assign cap_sr_d = {cap_sr_q[READ_LATENCY-2:0], rd_q};
    end
    assign cap = cap_sr_q[READ_LATENCY-1];

    hw_accel_ram_reader_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cap),
        .wr_data (ram_rdata),
        .rd_en   (m_ready),
        .rd_data (fifo_data),
        .valid   (fifo_valid),
        .count   (fifo_count)
    );

    assign pop = fifo_valid & m_ready;
    // A slot freed by this cycle's pop may be reused by this cycle's issue
    assign used      = ({1'b0, inflight_q} + {1'b0, fifo_count}) - (CREDIT_W+1)'(pop);
    assign credit_ok = (used < (CREDIT_W+1)'(FIFO_DEPTH));

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rd_d         = 1'b0;
        iss_left_d   = iss_left_q;
        beats_left_d = beats_left_q - {{ADDR_WIDTH{1'b0}}, pop};
        zero_done_d  = 1'b0;
        last_accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        state_d      = ST_READ;
                        addr_d       = start_addr;
                        rd_d         = 1'b1;
                        iss_left_d   = length - LEN_ONE;
                        beats_left_d = length;
                    end
                end
            end
            ST_READ: begin
                if (iss_left_q == '0) begin
                    state_d = ST_DRAIN;
                end else if (credit_ok) begin
                    rd_d       = 1'b1;
                    addr_d     = addr_q + ADDR_ONE;
                    iss_left_d = iss_left_q - LEN_ONE;
                    if (iss_left_q == LEN_ONE) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && (beats_left_q == LEN_ONE)) begin
                    state_d     = ST_IDLE;
                    last_accept = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        inflight_d = inflight_q + CREDIT_W'(rd_d) - CREDIT_W'(cap);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            rd_q         <= 1'b0;
            iss_left_q   <= '0;
            beats_left_q <= '0;
            inflight_q   <= '0;
            zero_done_q  <= 1'b0;
            cap_sr_q     <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rd_q         <= rd_d;
            iss_left_q   <= iss_left_d;
            beats_left_q <= beats_left_d;
            inflight_q   <= inflight_d;
            zero_done_q  <= zero_done_d;
            cap_sr_q     <= cap_sr_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = zero_done_q | last_accept;
    assign ram_addr = addr_q;
    assign ram_rd   = rd_q;
    assign m_valid  = fifo_valid;
    assign m_data   = fifo_data;

`ifdef HW_ACCEL_RAM_READER_LAST_EN
    assign m_last = fifo_valid & (beats_left_q == LEN_ONE);
`endif

endmodule

`default_nettype wire

// File: tb/tb_hw_accel_ram_stream_reader.sv
// ============================================================================
// Module  : tb_hw_accel_ram_stream_reader
// Brief   : Self-checking bench; runs READ_LATENCY=1 and =2 instances side by side.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_hw_accel_ram_stream_reader;

    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic          m_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ram_fn(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int RL = gi + 1;

        logic          busy, done, ram_rd, m_valid;
        logic [AW-1:0] ram_addr;
        logic [DW-1:0] ram_rdata, m_data;
        logic [DW-1:0] rd1_q, rd2_q;
`ifdef HW_ACCEL_RAM_READER_LAST_EN
        logic          m_last;
`endif

        hw_accel_ram_stream_reader #(
            .DATA_WIDTH   (DW),
            .ADDR_WIDTH   (AW),
            .READ_LATENCY (RL)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start),
            .start_addr (start_addr),
            .length     (length),
            .busy       (busy),
            .done       (done),
            .ram_addr   (ram_addr),
            .ram_rd     (ram_rd),
            .ram_rdata  (ram_rdata),
            .m_valid    (m_valid),
            .m_ready    (m_ready),
            .m_data     (m_data)
`ifdef HW_ACCEL_RAM_READER_LAST_EN
            ,
            .m_last     (m_last)
`endif
        );

        // RAM model: synchronous read, optional output register
        always @(posedge clk) begin
            if (ram_rd) rd1_q <= ram_fn(ram_addr);
            rd2_q <= rd1_q;
        end
        assign ram_rdata = (RL == 1) ? rd1_q : rd2_q;

        // Behavioural model: queues of addresses still to be issued / delivered
        logic [AW-1:0] iss_q[$];
        logic [AW-1:0] beat_q[$];
        bit            exp_busy = 0, zero_pend = 0, prev_stall = 0;
        logic [DW-1:0] prev_data;
        logic [DW-1:0] log_d [16];
        int cyc = 0, iss_cnt = 0, acc_cnt = 0, start_cyc = 0, first_cyc = 0;
        int first_lat = -1, beats = 0, dones = 0, span = 0, done_lat = -1;
        int lasts = 0, last_idx = -1;

        always @(negedge clk) begin : chk
            bit            burst_end, nb;
            logic [AW-1:0] a;
            cyc++;
            if (rst) begin
                check($sformatf("reset_outputs_rl%0d", RL),
                      {busy, done, ram_rd, ram_addr, m_valid, m_data}, 0);
`ifdef HW_ACCEL_RAM_READER_LAST_EN
                check("reset_m_last", m_last, 0);
`endif
                iss_q.delete();
                beat_q.delete();
                exp_busy = 0; zero_pend = 0; prev_stall = 0;
                iss_cnt = 0; acc_cnt = 0;
            end else begin
                burst_end = 0;
                if (ram_rd) begin
                    iss_cnt++;
                    if (iss_q.size() == 0) begin
                        check("unexpected_ram_rd", 1, 0);
                    end else begin
                        a = iss_q.pop_front();
                        check("ram_addr", ram_addr, a);
                    end
                    check("credit_limit", (iss_cnt - acc_cnt) <= 4, 1);
                end
                if (prev_stall) begin
                    check("hold_valid", m_valid, 1);
                    check("hold_data", m_data, prev_data);
                end
                if (m_valid && first_lat < 0) begin
                    first_lat = cyc - start_cyc;
                    first_cyc = cyc;
                end
`ifdef HW_ACCEL_RAM_READER_LAST_EN
                check("m_last", m_last, m_valid && beat_q.size() == 1);
                if (m_valid && m_ready && m_last) begin
                    lasts++;
                    last_idx = beats;
                end
`endif
                if (m_valid && m_ready) begin
                    if (beat_q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        a = beat_q.pop_front();
                        check("m_data", m_data, ram_fn(a));
                        if (beats < 16) log_d[beats] = m_data;
                        beats++;
                        span = cyc - first_cyc;
                        if (beat_q.size() == 0) burst_end = 1;
                    end
                    acc_cnt++;
                end
                check("done", done, zero_pend | burst_end);
                if (done) begin
                    dones++;
                    done_lat = cyc - start_cyc;
                end
                check("busy", busy, exp_busy);

                nb = exp_busy;
                if (burst_end) nb = 0;
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                zero_pend  = 0;
                if (start && !exp_busy) begin
                    beats = 0; dones = 0; lasts = 0; first_lat = -1;
                    done_lat = -1; last_idx = -1; start_cyc = cyc;
                    if (length == '0) begin
                        zero_pend = 1;
                    end else begin
                        nb = 1;
                        for (int i = 0; i < int'(length); i++) begin
                            a = start_addr + AW'(i);
                            iss_q.push_back(a);
                            beat_q.push_back(a);
                        end
                    end
                end
                exp_busy = nb;
            end
        end
    end

    task automatic do_start(input logic [AW-1:0] a, input int len);
        @(posedge clk); #1;
        start      = 1'b1;
        start_addr = a;
        length     = (AW+1)'(len);
        @(posedge clk); #1;
        start      = 1'b0;
        start_addr = ~a;
        length     = (AW+1)'(len + 3);
    endtask

    // mode 0: m_ready held high; mode 1: m_ready high one cycle in three
    task automatic wait_idle(input int mode);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            m_ready = (mode == 0) ? 1'b1 : ((i % 3) == 0);
            if (!g_dut[0].busy && !g_dut[1].busy) begin
                ok = 1;
                break;
            end
        end
        m_ready = 1'b1;
        check("wait_idle_timeout", ok, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bit ok;
        rst = 1'b1; start = 1'b0; start_addr = '0; length = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Basic burst, sustained throughput
        do_start(10'h010, 8);
        wait_idle(0);
        check("tc1_first_lat_rl1", g_dut[0].first_lat, 3);
        check("tc1_first_lat_rl2", g_dut[1].first_lat, 4);
        check("tc1_beats", g_dut[0].beats, 8);
        check("tc1_dones", g_dut[0].dones, 1);
        check("tc1_span_rl1", g_dut[0].span, 7);
        check("tc1_span_rl2", g_dut[1].span, 7);
        check("tc1_first_data", g_dut[0].log_d[0], 8'hB5);
        check("tc1_last_data", g_dut[0].log_d[7], 8'hB2);

        // Address wrap-around
        do_start(10'h3FE, 4);
        wait_idle(0);
        check("tc2_beats", g_dut[1].beats, 4);
        check("tc2_d0", g_dut[1].log_d[0], 8'h5B);
        check("tc2_d1", g_dut[1].log_d[1], 8'h5A);
        check("tc2_d2", g_dut[1].log_d[2], 8'hA5);
        check("tc2_d3", g_dut[1].log_d[3], 8'hA4);

        // Backpressure, ready one cycle in three
        do_start(10'h123, 16);
        wait_idle(1);
        check("tc3_beats_rl1", g_dut[0].beats, 16);
        check("tc3_beats_rl2", g_dut[1].beats, 16);
        check("tc3_dones", g_dut[1].dones, 1);

        // Zero length, then start pulsed while busy
        do_start(10'h050, 0);
        wait_idle(0);
        check("tc4_zero_dones", g_dut[0].dones, 1);
        check("tc4_zero_done_lat", g_dut[0].done_lat, 1);
        check("tc4_zero_beats", g_dut[1].beats, 0);
        do_start(10'h060, 4);
        do_start(10'h200, 5);
        wait_idle(0);
        check("tc4_busy_beats", g_dut[0].beats, 4);
        check("tc4_busy_dones", g_dut[1].dones, 1);
        check("tc4_busy_last", g_dut[0].log_d[3], 8'hC6);

        // Reset mid-burst, then a fresh short burst
        do_start(10'h100, 10);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (g_dut[0].beats >= 5) begin
                ok = 1;
                break;
            end
        end
        check("tc5_reach_5_beats", ok, 1);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("tc5_beats_at_reset", g_dut[0].beats, 5);
        check("tc5_no_done_rl1", g_dut[0].dones, 0);
        check("tc5_no_done_rl2", g_dut[1].dones, 0);
        do_start(10'h200, 2);
        wait_idle(0);
        check("tc5_new_beats_rl1", g_dut[0].beats, 2);
        check("tc5_new_beats_rl2", g_dut[1].beats, 2);
        check("tc5_new_d0", g_dut[0].log_d[0], 8'hA5);
        check("tc5_new_d1", g_dut[1].log_d[1], 8'hA4);

`ifdef HW_ACCEL_RAM_READER_LAST_EN
        do_start(10'h030, 3);
        wait_idle(0);
        check("tc6_lasts", g_dut[0].lasts, 1);
        check("tc6_last_idx", g_dut[0].last_idx, 2);
        check("tc6_last_idx_rl2", g_dut[1].last_idx, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
